// File: rtl/wash_phase_timer_pkg.sv
// Shared types and the per-program duration table for the washer phase timer.
package wash_timer_pkg;

  localparam int DUR_W = 8;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_WASH       = 3'd1,
    PH_RINSE_WAIT = 3'd2,
    PH_RINSE      = 3'd3,
    PH_SPIN_WAIT  = 3'd4,
    PH_SPIN       = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2,
    PROG_RSVD   = 2'd3
  } prog_e;

  typedef enum logic [1:0] {
    SEG_WASH  = 2'd0,
    SEG_RINSE = 2'd1,
    SEG_SPIN  = 2'd2
  } seg_e;

  // Reserved code runs as a normal program.
  function automatic prog_e norm_prog(logic [1:0] p);
    return (p == 2'd3) ? PROG_NORMAL : prog_e'(p);
  endfunction

  function automatic logic [DUR_W-1:0] dur(prog_e p, seg_e s);
    logic [DUR_W-1:0] w, r, sp;
    case (p)
      PROG_QUICK: begin w = 8'd5;  r = 8'd3;  sp = 8'd2; end
      PROG_HEAVY: begin w = 8'd20; r = 8'd10; sp = 8'd8; end
      default:    begin w = 8'd10; r = 8'd6;  sp = 8'd4; end
    endcase
    case (s)
      SEG_WASH:  return w;
      SEG_RINSE: return r;
      default:   return sp;
    endcase
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Washer-facing signal bundle for the phase timer; slave is the timer side.
interface wash_phase_timer_if;
  logic       start;
  logic       door_close;
  logic [1:0] prog;
  logic       motor_on;
  logic       fill_value_on;
  logic       drain_value_on;
  logic       drained;
  logic       abort;
  logic       fault_clr;
  logic       cycle_timeout;
  logic       spin_timeout;
  logic [7:0] remaining;
  logic [2:0] phase;
  logic       busy;
  logic       fault;

  modport slave (
    input  start, door_close, prog, motor_on, fill_value_on, drain_value_on,
           drained, abort, fault_clr,
    output cycle_timeout, spin_timeout, remaining, phase, busy, fault
  );

  modport master (
    output start, door_close, prog, motor_on, fill_value_on, drain_value_on,
           drained, abort, fault_clr,
    input  cycle_timeout, spin_timeout, remaining, phase, busy, fault
  );
endinterface

// File: rtl/wash_phase_timer_tick_prescaler.sv
// Free-running 0..CLK_PER_TICK-1 divider; tick is high on the wrap cycle.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(CLK_PER_TICK);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wash_phase_timer.sv
// Wash/rinse/spin sequencer generating washer timeouts, plus fill/drain watchdog.
import wash_timer_pkg::*;

module wash_phase_timer #(
  parameter int CLK_PER_TICK = 100000000,
  parameter int FAULT_TICKS  = 120
) (
  input logic clk,
  input logic reset,
  wash_phase_timer_if.slave bus
);
  localparam int WW = $clog2(FAULT_TICKS + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(FAULT_TICKS);

  phase_e           state_q, state_d;
  prog_e            prog_q, prog_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             cto_q, cto_d, sto_q, sto_d;
  logic             fault_q, fault_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             ph_clear, ph_en, ph_tick;
  logic             wd_act, wd_tick;

  // Prescaler restarts on every timed-phase entry so each phase is exactly N ticks.
  assign ph_clear = bus.abort
                  | ((state_q == PH_IDLE || state_q == PH_RINSE_WAIT) && bus.motor_on)
                  | ((state_q == PH_SPIN_WAIT) && bus.drain_value_on && bus.drained);
  assign ph_en    = (state_q == PH_SPIN)
                  | ((state_q == PH_WASH || state_q == PH_RINSE) && bus.motor_on);

  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_ph_pre (
    .clk(clk), .reset(reset), .clear(ph_clear), .enable(ph_en), .tick(ph_tick)
  );

  assign wd_act = bus.fill_value_on | bus.drain_value_on;

  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_wd_pre (
    .clk(clk), .reset(reset), .clear(~wd_act), .enable(wd_act), .tick(wd_tick)
  );

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    rem_d   = rem_q;
    cto_d   = 1'b0;
    sto_d   = 1'b0;
    if (bus.abort) begin
      state_d = PH_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        PH_IDLE: begin
          if (bus.start && bus.door_close) prog_d = norm_prog(bus.prog);
          if (bus.motor_on) begin
            state_d = PH_WASH;
            rem_d   = dur(prog_d, SEG_WASH);
          end
        end
        PH_WASH, PH_RINSE: begin
          if (ph_tick) begin
            if (rem_q == 8'd1) begin
              rem_d   = '0;
              cto_d   = 1'b1;
              state_d = (state_q == PH_WASH) ? PH_RINSE_WAIT : PH_SPIN_WAIT;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        PH_RINSE_WAIT: begin
          if (bus.motor_on) begin
            state_d = PH_RINSE;
            rem_d   = dur(prog_q, SEG_RINSE);
          end
        end
        PH_SPIN_WAIT: begin
          if (bus.drain_value_on && bus.drained) begin
            state_d = PH_SPIN;
            rem_d   = dur(prog_q, SEG_SPIN);
          end
        end
        PH_SPIN: begin
          if (ph_tick) begin
            if (rem_q == 8'd1) begin
              rem_d   = '0;
              sto_d   = 1'b1;
              state_d = PH_IDLE;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = PH_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Watchdog saturates at the limit; clear beats a same-cycle set.
  always_comb begin
    wd_d = wd_q;
    if (!wd_act)                        wd_d = '0;
    else if (wd_tick && wd_q != WD_MAX) wd_d = wd_q + 1'b1;
    fault_d = fault_q | (wd_d == WD_MAX);
    if (bus.fault_clr) fault_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PH_IDLE;
      prog_q  <= PROG_NORMAL;
      rem_q   <= '0;
      cto_q   <= 1'b0;
      sto_q   <= 1'b0;
      fault_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      rem_q   <= rem_d;
      cto_q   <= cto_d;
      sto_q   <= sto_d;
      fault_q <= fault_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.cycle_timeout = cto_q;
  assign bus.spin_timeout  = sto_q;
  assign bus.remaining     = rem_q;
  assign bus.phase         = state_q;
  assign bus.busy          = (state_q != PH_IDLE);
  assign bus.fault         = fault_q;
endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboarded bench: timeout pulses are matched against queued expectations.
module tb_wash_phase_timer;
  localparam logic [1:0] K_CT = 2'b01;
  localparam logic [1:0] K_ST = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wash_phase_timer_if ifa ();
  wash_phase_timer_if ifw ();

  wash_phase_timer #(.CLK_PER_TICK(4), .FAULT_TICKS(120)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  wash_phase_timer #(.CLK_PER_TICK(2), .FAULT_TICKS(3)) u_w (
    .clk(clk), .reset(reset), .bus(ifw)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] kind;
    int         at;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns 1 time unit after posedge number t.
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] k, input int t);
    exp_t e;
    e.kind = k;
    e.at   = t;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    logic [1:0] k;
    forever begin
      @(negedge clk);
      k = {ifa.spin_timeout, ifa.cycle_timeout};
      if (k != 2'b00) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_timeout: got kind %b at cyc %0d, expected none", k, cyc);
        end else begin
          e = sb.pop_front();
          if (k !== e.kind || cyc != e.at) begin
            n_bad++;
            $display("FAIL timeout_pulse: got kind %b at cyc %0d, expected kind %b at cyc %0d",
                     k, cyc, e.kind, e.at);
          end
        end
      end
    end
  endtask

  task automatic launch(input logic [1:0] p);
    ifa.prog = p; ifa.start = 1'b1; ifa.door_close = 1'b1;
    at(cyc + 1);
    ifa.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at cyc %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int c, d;
    {ifa.start, ifa.door_close, ifa.prog, ifa.motor_on, ifa.fill_value_on,
     ifa.drain_value_on, ifa.drained, ifa.abort, ifa.fault_clr} = '0;
    {ifw.start, ifw.door_close, ifw.prog, ifw.motor_on, ifw.fill_value_on,
     ifw.drain_value_on, ifw.drained, ifw.abort, ifw.fault_clr} = '0;
    fork monitor(); join_none

    at(3);
    chk("rst_phase", ifa.phase, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_remaining", ifa.remaining, 0);
    chk("rst_timeouts", {ifa.spin_timeout, ifa.cycle_timeout}, 0);
    chk("rst_fault", ifa.fault, 0);
    reset = 1'b0;
    at(cyc + 2);

    // Quick program, motor held: full wash -> rinse -> spin.
    launch(2'd0);
    c = cyc;
    ifa.motor_on = 1'b1;
    push(K_CT, c + 21);
    push(K_CT, c + 34);
    for (int k = 0; k < 5; k++) begin
      at(c + 1 + 4 * k);
      chk("quick_wash_rem", ifa.remaining, 5 - k);
    end
    chk("wash_busy", ifa.busy, 1);
    chk("wash_phase", ifa.phase, 1);
    at(c + 21);
    chk("wash_end_rem", ifa.remaining, 0);
    chk("rinse_wait_phase", ifa.phase, 2);
    at(c + 22);
    chk("rinse_phase", ifa.phase, 3);
    chk("quick_rinse_rem", ifa.remaining, 3);
    at(c + 34);
    chk("spin_wait_phase", ifa.phase, 4);
    ifa.motor_on = 1'b0;
    d = cyc;
    ifa.drain_value_on = 1'b1; ifa.drained = 1'b1;
    push(K_ST, d + 9);
    at(d + 1);
    chk("spin_phase", ifa.phase, 5);
    chk("quick_spin_rem", ifa.remaining, 2);
    ifa.drain_value_on = 1'b0; ifa.drained = 1'b0;
    at(d + 9);
    chk("spin_done_phase", ifa.phase, 0);
    chk("spin_done_busy", ifa.busy, 0);
    at(cyc + 2);

    // Normal program with a 7-clock motor pause mid-wash.
    launch(2'd1);
    c = cyc;
    ifa.motor_on = 1'b1;
    push(K_CT, c + 48);
    at(c + 14);
    chk("pause_rem_before", ifa.remaining, 7);
    ifa.motor_on = 1'b0;
    at(c + 21);
    chk("pause_rem_after", ifa.remaining, 7);
    ifa.motor_on = 1'b1;
    at(c + 47);
    chk("pause_last_rem", ifa.remaining, 1);
    at(c + 48);
    chk("pause_phase", ifa.phase, 2);
    ifa.motor_on = 1'b0; ifa.abort = 1'b1;
    at(c + 49);
    ifa.abort = 1'b0;
    chk("abort_wait_phase", ifa.phase, 0);
    at(cyc + 2);

    // Abort seen on the edge of the final wash tick.
    launch(2'd0);
    c = cyc;
    ifa.motor_on = 1'b1;
    at(c + 20);
    chk("abort_pre_rem", ifa.remaining, 1);
    ifa.abort = 1'b1;
    at(c + 21);
    ifa.abort = 1'b0; ifa.motor_on = 1'b0;
    chk("abort_phase", ifa.phase, 0);
    chk("abort_rem", ifa.remaining, 0);
    chk("abort_no_pulse", ifa.cycle_timeout, 0);
    at(c + 23);
    chk("abort_stays_idle", ifa.phase, 0);

    // Reserved program behaves as normal; async reset in mid-spin.
    launch(2'd3);
    c = cyc;
    ifa.motor_on = 1'b1;
    push(K_CT, c + 41);
    push(K_CT, c + 66);
    at(c + 1);
    chk("p3_wash_rem", ifa.remaining, 10);
    at(c + 42);
    chk("p3_rinse_rem", ifa.remaining, 6);
    at(c + 66);
    chk("p3_spin_wait", ifa.phase, 4);
    ifa.motor_on = 1'b0;
    d = cyc;
    ifa.drain_value_on = 1'b1; ifa.drained = 1'b1;
    at(d + 1);
    chk("p3_spin_rem", ifa.remaining, 4);
    ifa.drain_value_on = 1'b0; ifa.drained = 1'b0;
    at(d + 3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_phase", ifa.phase, 0);
    chk("async_rst_rem", ifa.remaining, 0);
    chk("async_rst_busy", ifa.busy, 0);
    chk("async_rst_timeouts", {ifa.spin_timeout, ifa.cycle_timeout}, 0);
    at(cyc + 2);
    reset = 1'b0;
    at(cyc + 2);

    // Watchdog: 3 ticks of 2 clocks.
    c = cyc;
    ifw.fill_value_on = 1'b1;
    at(c + 5);
    chk("wd_before", ifw.fault, 0);
    at(c + 6);
    chk("wd_set", ifw.fault, 1);
    at(c + 8);
    ifw.fill_value_on = 1'b0;
    at(c + 10);
    chk("wd_sticky", ifw.fault, 1);
    ifw.fault_clr = 1'b1;
    at(c + 11);
    ifw.fault_clr = 1'b0;
    chk("wd_cleared", ifw.fault, 0);
    c = cyc;
    ifw.drain_value_on = 1'b1;
    at(c + 5);
    ifw.fault_clr = 1'b1;
    at(c + 6);
    chk("wd_clr_wins", ifw.fault, 0);
    ifw.fault_clr = 1'b0;
    at(c + 7);
    chk("wd_saturated_reset", ifw.fault, 1);
    ifw.drain_value_on = 1'b0;

    at(cyc + 3);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
